// File: rtl/atf_kept_packet_stream_if.sv
// AXI-Stream link carrying kept trace packets from atf_kept_packet_stream
// to the DMA engine.
//   tdata  : packet payload (DATA_WIDTH bits)
//   tvalid : master holds a packet
//   tready : slave accepts the packet this cycle
//   tlast  : final beat of the current DMA frame
interface atf_kept_packet_stream_if #(
  parameter int DATA_WIDTH = 1024
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/atf_kept_packet_stream.sv
// Kept-packet stream stage behind the advanced trace filter.
//
// Each incoming trace packet travels down a delay line so that it arrives
// together with the filter's registered keep/drop decision. Kept packets go
// into a first-word-fall-through FIFO that drains as an AXI-Stream master;
// TLAST closes a frame every PKTS_PER_TLAST beats or early on flush.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   en              capture enable shared with the filter
//   data_pkt        trace packet, same cycle as the filter input
//   data_pkt_valid  data_pkt carries a new packet
//   keep_pkt        filter decision: keep (wins if drop_pkt is also high)
//   drop_pkt        filter decision: drop
//   flush           one-cycle request to end the current frame early
//   m_axis          AXI-Stream master (tdata/tvalid/tready/tlast)
//   kept_count      packets written into the FIFO (saturating)
//   dropped_count   packets the filter dropped (saturating)
//   overflow_count  kept packets lost to a full FIFO (saturating)
//   fifo_level      FIFO occupancy, registered
module atf_kept_packet_stream #(
  parameter int DATA_WIDTH       = 1024,
  parameter int DECISION_LATENCY = 2,
  parameter int FIFO_DEPTH       = 16,
  parameter int PKTS_PER_TLAST   = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [DATA_WIDTH-1:0]         data_pkt,
  input  logic                          data_pkt_valid,
  input  logic                          keep_pkt,
  input  logic                          drop_pkt,
  input  logic                          flush,
  atf_kept_packet_stream_if.master      m_axis,
  output logic [31:0]                   kept_count,
  output logic [31:0]                   dropped_count,
  output logic [31:0]                   overflow_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (PKTS_PER_TLAST > 1) ? $clog2(PKTS_PER_TLAST) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKTS_PER_TLAST - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

  // ---------------- decision-alignment delay line ----------------
  logic [DATA_WIDTH-1:0]       dl_data_q [DECISION_LATENCY];
  logic [DATA_WIDTH-1:0]       dl_data_d [DECISION_LATENCY];
  logic [DECISION_LATENCY-1:0] dl_valid_q, dl_valid_d;

  // NOTE: every always_comb output gets a default before any branch or loop,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    dl_data_d  = dl_data_q;
    dl_valid_d = '0;
    // en gates only new packets; ones already in flight still resolve.
    dl_data_d[0]  = data_pkt;
    dl_valid_d[0] = en & data_pkt_valid;
    for (int i = 1; i < DECISION_LATENCY; i++) begin
      dl_data_d[i]  = dl_data_q[i-1];
      dl_valid_d[i] = dl_valid_q[i-1];
    end
  end

  logic [DATA_WIDTH-1:0] d_data;
  logic                  d_valid;
  assign d_data  = dl_data_q[DECISION_LATENCY-1];
  assign d_valid = dl_valid_q[DECISION_LATENCY-1];

  // ---------------- FIFO control ----------------
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  full, pop, push_req, push, lost, drop_ev;

  assign full     = (level_q == FULL_LVL);
  assign pop      = m_axis.tvalid & m_axis.tready;
  // Both decision bits high counts as keep.
  assign push_req = d_valid & keep_pkt;
  // A pop in the same cycle frees the slot being written, so a full FIFO
  // still accepts; when full, wr_ptr equals rd_ptr and the head is read out
  // before the edge overwrites it.
  assign push     = push_req & (~full | pop);
  assign lost     = push_req & full & ~pop;
  assign drop_ev  = d_valid & drop_pkt & ~keep_pkt;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // ---------------- saturating counters ----------------
  logic [31:0] kept_q, kept_d, dropped_q, dropped_d, ovf_q, ovf_d;

  always_comb begin
    kept_d    = kept_q;
    dropped_d = dropped_q;
    ovf_d     = ovf_q;
    if (push    && kept_q    != '1) kept_d    = kept_q    + 32'd1;
    if (drop_ev && dropped_q != '1) dropped_d = dropped_q + 32'd1;
    if (lost    && ovf_q     != '1) ovf_d     = ovf_q     + 32'd1;
  end

  // ---------------- framing ----------------
  logic [BW-1:0] beat_q, beat_d;
  logic          flush_pending_q, flush_pending_d;
  logic          tlast_int;

  // flush_pending reaches tlast only from the register, so a flush pulse
  // always lands on a later beat than the one transferring this cycle.
  assign tlast_int = m_axis.tvalid & ((beat_q == LAST_BEAT) | flush_pending_q);

  always_comb begin
    beat_d          = beat_q;
    flush_pending_d = flush_pending_q;
    if (pop) begin
      if (tlast_int) begin
        beat_d          = '0;
        flush_pending_d = 1'b0;
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end
    // A new flush outranks the clear from a tlast transfer in the same cycle.
    if (flush) flush_pending_d = 1'b1;
  end

  // ---------------- registers ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dl_valid_q      <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      kept_q          <= '0;
      dropped_q       <= '0;
      ovf_q           <= '0;
      beat_q          <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      dl_valid_q      <= dl_valid_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      kept_q          <= kept_d;
      dropped_q       <= dropped_d;
      ovf_q           <= ovf_d;
      beat_q          <= beat_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  // NOTE: payload storage is deliberately not reset; the valid bits and
  // level above decide whether any of it is meaningful.
  always_ff @(posedge clk) begin
    dl_data_q <= dl_data_d;
    if (push) mem_q[wr_ptr_q] <= d_data;
  end

  // ---------------- outputs ----------------
  assign m_axis.tdata   = mem_q[rd_ptr_q];
  assign m_axis.tvalid  = (level_q != '0);
  assign m_axis.tlast   = tlast_int;
  assign kept_count     = kept_q;
  assign dropped_count  = dropped_q;
  assign overflow_count = ovf_q;
  assign fifo_level     = level_q;

endmodule

// File: tb/tb_atf_kept_packet_stream.sv
// Directed testbench for atf_kept_packet_stream with a small FIFO and short
// frames. A two-stage filter model supplies keep/drop LAT cycles after each
// packet; a negedge monitor logs every AXI-Stream transfer.
module tb_atf_kept_packet_stream;

  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int PKTS  = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n, en, data_pkt_valid, keep_pkt, drop_pkt, flush;
  logic [DW-1:0] data_pkt;
  logic [31:0]   kept_count, dropped_count, overflow_count;
  logic [LW-1:0] fifo_level;

  atf_kept_packet_stream_if #(.DATA_WIDTH(DW)) axis ();

  atf_kept_packet_stream #(
    .DATA_WIDTH(DW), .DECISION_LATENCY(LAT),
    .FIFO_DEPTH(DEPTH), .PKTS_PER_TLAST(PKTS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .data_pkt(data_pkt), .data_pkt_valid(data_pkt_valid),
    .keep_pkt(keep_pkt), .drop_pkt(drop_pkt), .flush(flush),
    .m_axis(axis),
    .kept_count(kept_count), .dropped_count(dropped_count),
    .overflow_count(overflow_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t rx[$];
  int checks = 0;
  int errors = 0;

  // Filter model: decision for a packet appears LAT cycles after it.
  logic [LAT-1:0] fv, fk, fd;

  always @(negedge clk)
    if (rst_n && axis.tvalid && axis.tready) rx.push_back({axis.tlast, axis.tdata});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic k, input logic dr);
    data_pkt_valid = v;
    data_pkt       = d;
    keep_pkt       = fv[LAT-1] & fk[LAT-1];
    drop_pkt       = fv[LAT-1] & fd[LAT-1];
    for (int i = LAT - 1; i > 0; i--) begin
      fv[i] = fv[i-1]; fk[i] = fk[i-1]; fd[i] = fd[i-1];
    end
    fv[0] = v; fk[0] = k; fd[0] = dr;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; axis.tready = 1'b0;
    data_pkt_valid = 1'b0; data_pkt = '0; keep_pkt = 1'b0; drop_pkt = 1'b0;
    fv = '0; fk = '0; fd = '0;
    tick(); tick();
    rx.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (axis.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", axis.tvalid); end
    checks++; if (axis.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", axis.tlast); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (kept_count !== 32'd0) begin errors++; $display("FAIL reset_kept got %0d want 0", kept_count); end
    checks++; if (dropped_count !== 32'd0) begin errors++; $display("FAIL reset_dropped got %0d want 0", dropped_count); end
    checks++; if (overflow_count !== 32'd0) begin errors++; $display("FAIL reset_overflow got %0d want 0", overflow_count); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 'hA; exp_d[1] = 'hC; exp_d[2] = 'hD;
    do_reset();
    axis.tready = 1'b1;
    cycle(1'b1, 'hA, 1'b1, 1'b0);
    cycle(1'b1, 'hB, 1'b0, 1'b1);
    cycle(1'b1, 'hC, 1'b1, 1'b0);
    cycle(1'b1, 'hD, 1'b1, 1'b0);
    idle(8);
    checks++; if (rx.size() !== 3) begin errors++; $display("FAIL basic_beats got %0d want 3", rx.size()); end
    for (int i = 0; i < 3 && i < rx.size(); i++) begin
      checks++; if (rx[i] !== {1'b0, exp_d[i]}) begin errors++; $display("FAIL basic_beat%0d got %h want %h", i, rx[i], {1'b0, exp_d[i]}); end
    end
    checks++; if (kept_count !== 32'd3) begin errors++; $display("FAIL basic_kept got %0d want 3", kept_count); end
    checks++; if (dropped_count !== 32'd1) begin errors++; $display("FAIL basic_dropped got %0d want 1", dropped_count); end
    checks++; if (overflow_count !== 32'd0) begin errors++; $display("FAIL basic_overflow got %0d want 0", overflow_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, DW'(32'h10 + i), 1'b1, 1'b0);
    idle(3);
    checks++; if (fifo_level !== LW'(4)) begin errors++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
    checks++; if (kept_count !== 32'd4) begin errors++; $display("FAIL ovf_kept got %0d want 4", kept_count); end
    checks++; if (overflow_count !== 32'd2) begin errors++; $display("FAIL ovf_overflow got %0d want 2", overflow_count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (axis.tvalid !== 1'b1) begin errors++; $display("FAIL ovf_stall_tvalid got %b want 1", axis.tvalid); end
      checks++; if (axis.tdata !== DW'(32'h10)) begin errors++; $display("FAIL ovf_stall_tdata got %h want 10", axis.tdata); end
      checks++; if (axis.tlast !== 1'b0) begin errors++; $display("FAIL ovf_stall_tlast got %b want 0", axis.tlast); end
      idle(1);
    end
    axis.tready = 1'b1;
    idle(8);
    checks++; if (rx.size() !== 4) begin errors++; $display("FAIL ovf_beats got %0d want 4", rx.size()); end
    for (int i = 0; i < 4 && i < rx.size(); i++) begin
      checks++; if (rx[i] !== {(i == 3), DW'(32'h10 + i)}) begin errors++; $display("FAIL ovf_beat%0d got %h", i, rx[i]); end
    end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL ovf_drained got %0d want 0", fifo_level); end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      axis.tready = (i >= LAT + DEPTH);
      cycle(i < 16, DW'(32'h100 + i), 1'b1, 1'b0);
      if (i >= LAT + DEPTH) begin
        checks++; if (fifo_level !== LW'(4)) begin errors++; $display("FAIL full_level c%0d got %0d want 4", i, fifo_level); end
        checks++; if (overflow_count !== 32'd0) begin errors++; $display("FAIL full_overflow c%0d got %0d want 0", i, overflow_count); end
      end
    end
    idle(8);
    checks++; if (rx.size() !== 16) begin errors++; $display("FAIL full_beats got %0d want 16", rx.size()); end
    for (int i = 0; i < 16 && i < rx.size(); i++) begin
      checks++; if (rx[i] !== {(i % 4 == 3), DW'(32'h100 + i)}) begin errors++; $display("FAIL full_beat%0d got %h", i, rx[i]); end
    end
    checks++; if (kept_count !== 32'd16) begin errors++; $display("FAIL full_kept got %0d want 16", kept_count); end
  endtask

  task automatic test_framing_flush();
    do_reset();
    axis.tready = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b1, DW'(32'h200 + i), 1'b1, 1'b0);
    idle(8);
    checks++; if (rx.size() !== 10) begin errors++; $display("FAIL frame_beats got %0d want 10", rx.size()); end
    for (int i = 0; i < 10 && i < rx.size(); i++) begin
      checks++; if (rx[i] !== {(i == 3 || i == 7), DW'(32'h200 + i)}) begin errors++; $display("FAIL frame_beat%0d got %h", i, rx[i]); end
    end
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(3);
    checks++; if (axis.tlast !== 1'b0) begin errors++; $display("FAIL flush_idle_tlast got %b want 0", axis.tlast); end
    cycle(1'b1, DW'(32'h2AA), 1'b1, 1'b0);
    idle(5);
    cycle(1'b1, DW'(32'h2BB), 1'b1, 1'b0);
    idle(5);
    checks++; if (rx.size() !== 12) begin errors++; $display("FAIL flush_beats got %0d want 12", rx.size()); end
    if (rx.size() == 12) begin
      checks++; if (rx[10] !== {1'b1, DW'(32'h2AA)}) begin errors++; $display("FAIL flush_beat got %h want 1_2aa", rx[10]); end
      checks++; if (rx[11] !== {1'b0, DW'(32'h2BB)}) begin errors++; $display("FAIL after_flush_beat got %h want 0_2bb", rx[11]); end
    end
  endtask

  task automatic test_decision_errors();
    do_reset();
    axis.tready = 1'b1;
    cycle(1'b1, DW'(32'h301), 1'b0, 1'b0);
    cycle(1'b1, DW'(32'h302), 1'b1, 1'b1);
    cycle(1'b1, DW'(32'h303), 1'b0, 1'b1);
    en = 1'b0;
    cycle(1'b1, DW'(32'h304), 1'b1, 1'b0);
    en = 1'b1;
    idle(6);
    checks++; if (kept_count !== 32'd1) begin errors++; $display("FAIL decerr_kept got %0d want 1", kept_count); end
    checks++; if (dropped_count !== 32'd1) begin errors++; $display("FAIL decerr_dropped got %0d want 1", dropped_count); end
    checks++; if (rx.size() !== 1) begin errors++; $display("FAIL decerr_beats got %0d want 1", rx.size()); end
    if (rx.size() == 1) begin
      checks++; if (rx[0].data !== DW'(32'h302)) begin errors++; $display("FAIL decerr_data got %h want 302", rx[0].data); end
    end
  endtask

  task automatic test_random_ready();
    int            sent = 0;
    logic          send, pre_v, pre_r, pre_l;
    logic [DW-1:0] pre_d;
    do_reset();
    for (int cyc = 0; cyc < 3000 && rx.size() < 100; cyc++) begin
      axis.tready = 1'($urandom_range(0, 1));
      send  = (sent < 100) && ((sent - rx.size()) < DEPTH) && ($urandom_range(0, 3) != 0);
      pre_v = axis.tvalid; pre_r = axis.tready; pre_d = axis.tdata; pre_l = axis.tlast;
      cycle(send, DW'(32'h1000 + sent), 1'b1, 1'b0);
      if (send) sent++;
      if (pre_v && !pre_r) begin
        checks++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== pre_d || axis.tlast !== pre_l) begin
          errors++;
          $display("FAIL rand_stall got v=%b d=%h l=%b want v=1 d=%h l=%b", axis.tvalid, axis.tdata, axis.tlast, pre_d, pre_l);
        end
      end
    end
    checks++; if (rx.size() !== 100) begin errors++; $display("FAIL rand_beats got %0d want 100 (cycle budget)", rx.size()); end
    for (int i = 0; i < 100 && i < rx.size(); i++) begin
      checks++; if (rx[i] !== {(i % 4 == 3), DW'(32'h1000 + i)}) begin errors++; $display("FAIL rand_beat%0d got %h", i, rx[i]); end
    end
    checks++; if (overflow_count !== 32'd0) begin errors++; $display("FAIL rand_overflow got %0d want 0", overflow_count); end
    checks++; if (kept_count !== 32'd100) begin errors++; $display("FAIL rand_kept got %0d want 100", kept_count); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    axis.tready = 1'b1;
    cycle(1'b1, DW'(32'h401), 1'b1, 1'b0);
    cycle(1'b1, DW'(32'h402), 1'b1, 1'b0);
    idle(5);
    axis.tready = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(32'h410 + i), 1'b1, 1'b0);
    idle(4);
    checks++; if (fifo_level !== LW'(3)) begin errors++; $display("FAIL mid_level got %0d want 3", fifo_level); end
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    checks++; if (axis.tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid got %b want 0", axis.tvalid); end
    checks++; if (axis.tlast !== 1'b0) begin errors++; $display("FAIL mid_rst_tlast got %b want 0", axis.tlast); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL mid_rst_level got %0d want 0", fifo_level); end
    checks++; if (kept_count !== 32'd0) begin errors++; $display("FAIL mid_rst_kept got %0d want 0", kept_count); end
    checks++; if (dropped_count !== 32'd0) begin errors++; $display("FAIL mid_rst_dropped got %0d want 0", dropped_count); end
    checks++; if (overflow_count !== 32'd0) begin errors++; $display("FAIL mid_rst_overflow got %0d want 0", overflow_count); end
    rx.delete();
    axis.tready = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(32'h420 + i), 1'b1, 1'b0);
    idle(8);
    checks++; if (rx.size() !== 4) begin errors++; $display("FAIL mid_new_beats got %0d want 4", rx.size()); end
    for (int i = 0; i < 4 && i < rx.size(); i++) begin
      checks++; if (rx[i] !== {(i == 3), DW'(32'h420 + i)}) begin errors++; $display("FAIL mid_new_beat%0d got %h", i, rx[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_framing_flush();
    test_decision_errors();
    test_random_ready();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
